fp_stream_driver: RTL and testbench

FP_STREAM_DRIVER -- requirements
Module: fp_stream_driver

---
 rtl/fp_stream_driver_pkg.sv | 21 ++
 rtl/fp_stream_driver_if.sv | 36 +++
 rtl/fp_vec_buf.sv | 41 ++++
 rtl/fp_stream_driver.sv | 140 ++++++++++++++
 tb/tb_fp_stream_driver.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_stream_driver_pkg.sv
// Shared definitions for the FP operand stream driver: state encoding,
// default geometry and counter widths.
package fp_stream_driver_pkg;

  localparam int DEF_SIZE       = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int RX_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index width for an n-entry buffer; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_stream_driver_if.sv
// AXI-Stream pair between the driver and the accelerator: m00 carries
// operands out to the accelerator, s00 carries results back.
interface fp_stream_driver_if
  import fp_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                    m00_axis_tvalid;
  logic [DATA_WIDTH-1:0]   m00_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;
  logic                    m00_axis_tlast;
  logic                    m00_axis_tready;

  logic                    s00_axis_tvalid;
  logic [DATA_WIDTH-1:0]   s00_axis_tdata;
  logic                    s00_axis_tlast;
  logic                    s00_axis_tready;

  // Driver side: sources the operand stream, sinks the result stream.
  modport master (
    output m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast,
    input  m00_axis_tready,
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
    output s00_axis_tready
  );

  // Accelerator side: the mirror image of the driver.
  modport slave (
    input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast,
    output m00_axis_tready,
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
    input  s00_axis_tready
  );

endinterface

// File: rtl/fp_vec_buf.sv
// Operand vector buffer: synchronous write, asynchronous read.
// Contents are intentionally not reset so operands survive a block reset.
module fp_vec_buf
  import fp_stream_driver_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = addr_width(DEF_SIZE)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];
  logic                  wr_ok;

  // Addresses beyond the last entry are dropped rather than aliased.
  always_comb begin
    wr_ok = we && (32'(waddr) < 32'(SIZE));
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read so the stream data follows idx with no extra cycle.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < 32'(SIZE)) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/fp_stream_driver.sv
// Streams an operand vector to an accelerator and captures its result stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; operand buffer writable
//   SEND    | presenting mem[idx] on m00; advances on each accepted beat
//   RECV    | accepting result beats on s00 until one carries tlast
//   DONE    | one-cycle done pulse, then back to IDLE
module fp_stream_driver
  import fp_stream_driver_pkg::*;
#(
  parameter  int SIZE       = DEF_SIZE,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int AW         = addr_width(SIZE)
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  fp_stream_driver_if.master      axis,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [RX_CNT_W-1:0]     rx_count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

  state_t                state_q,    state_d;
  logic [AW-1:0]         idx_q,      idx_d;
  logic [DATA_WIDTH-1:0] result_q,   result_d;
  logic [RX_CNT_W-1:0]   rx_count_q, rx_count_d;

  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic                  m_fire;
  logic                  s_fire;

  // Buffer is only writable while idle; a write coinciding with start lands
  // before the first SEND cycle reads it.
  always_comb begin
    buf_we = wr_en && (state_q == ST_IDLE);
  end

  fp_vec_buf #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_vec_buf (
    .clk   (s00_axi_aclk),
    .we    (buf_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q),
    .rdata (buf_rdata)
  );

  // State, index and capture registers; synchronous reset leaves buffer alone.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      result_q   <= '0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Handshake qualifiers; valid/ready are pure functions of the state register,
  // so neither depends combinationally on the partner's signal.
  always_comb begin
    m_fire = (state_q == ST_SEND) && axis.m00_axis_tready;
    s_fire = (state_q == ST_RECV) && axis.s00_axis_tvalid;
  end

  // Next-state, index advance and result capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    result_d   = result_q;
    rx_count_d = rx_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SEND;
          idx_d      = '0;
          rx_count_d = '0;
        end
      end
      ST_SEND: begin
        if (m_fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_RECV;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (s_fire) begin
          result_d = axis.s00_axis_tdata;
          if (rx_count_q != '1) begin
            rx_count_d = rx_count_q + 1'b1;
          end
          if (axis.s00_axis_tlast) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stream and status outputs decoded from the registered state.
  always_comb begin
    axis.m00_axis_tvalid = (state_q == ST_SEND);
    axis.m00_axis_tdata  = buf_rdata;
    axis.m00_axis_tstrb  = '1;
    axis.m00_axis_tlast  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    axis.s00_axis_tready = (state_q == ST_RECV);
    busy                 = (state_q != ST_IDLE);
    done                 = (state_q == ST_DONE);
    result               = result_q;
    rx_count             = rx_count_q;
  end

endmodule

// File: tb/tb_fp_stream_driver.sv
// Scoreboard bench for fp_stream_driver: expected operand beats are queued
// when a run starts and popped as the DUT hands them over.
module tb_fp_stream_driver;

  localparam int SIZE = 10;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic [15:0]   rx_count;

  fp_stream_driver_if #(.DATA_WIDTH(DW)) axis ();

  fp_stream_driver #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DW)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .start          (start),
    .axis           (axis),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .rx_count       (rx_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_model [SIZE];
  logic [31:0] exp_q [$];
  logic [31:0] rx_q  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: tready high; 1: tready 1,0,0,1 pattern; 2: reset after 4th beat;
  // 3: start and a write to addr 3 injected mid-send.
  task automatic send_phase(input int mode);
    int first = -1;
    int last  = -1;
    int beats = 0;
    for (int i = 0; i < SIZE; i++) exp_q.push_back(mem_model[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      axis.m00_axis_tready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (mode == 3 && c == 2) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 32'hDEADBEEF;
      end
      #3;
      if (axis.m00_axis_tvalid) begin
        check("tdata", axis.m00_axis_tdata, exp_q[0]);
        check("tlast", 32'(axis.m00_axis_tlast), 32'(exp_q.size() == 1));
        check("tstrb", 32'(axis.m00_axis_tstrb), 32'hF);
        if (axis.m00_axis_tready) begin
          void'(exp_q.pop_front());
          if (first < 0) first = c;
          last = c;
          beats++;
          if (mode == 2 && beats == 4) rst = 1'b1;
        end
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (mode == 2 && beats == 4) begin
        check("rst_tvalid", 32'(axis.m00_axis_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_q.delete();
      end
    end
    axis.m00_axis_tready = 1'b0;
    if (mode != 2) begin
      check("send_left", exp_q.size(), 32'd0);
      check("beats", beats, SIZE);
      if (mode != 1) begin
        check("first_beat_cycle", first, 32'd0);
        check("burst_span", last - first, SIZE - 1);
      end
      check("post_send_tvalid", 32'(axis.m00_axis_tvalid), 32'd0);
      check("recv_tready", 32'(axis.s00_axis_tready), 32'd1);
      check("busy_recv", 32'(busy), 32'd1);
    end
    exp_q.delete();
  endtask

  // Feeds rx_q as the result stream, with gap idle cycles before each beat.
  task automatic recv_phase(input int gap);
    int          n = rx_q.size();
    logic [31:0] last_d = rx_q[n-1];
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        axis.s00_axis_tvalid = 1'b0;
        tick();
        check("gap_no_done", 32'(done), 32'd0);
      end
      axis.s00_axis_tvalid = 1'b1;
      axis.s00_axis_tdata  = rx_q[i];
      axis.s00_axis_tlast  = (i == n - 1);
      tick();
    end
    axis.s00_axis_tvalid = 1'b0;
    axis.s00_axis_tlast  = 1'b0;
    axis.s00_axis_tdata  = 32'h0;
    check("done_pulse", 32'(done), 32'd1);
    tick();
    check("done_low", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tready", 32'(axis.s00_axis_tready), 32'd0);
    check("result", result, last_d);
    check("rx_count", 32'(rx_count), n);
    tick();
    check("done_once", 32'(done), 32'd0);
    check("result_hold", result, last_d);
    rx_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    axis.m00_axis_tready = 1'b0;
    axis.s00_axis_tvalid = 1'b0;
    axis.s00_axis_tdata  = '0;
    axis.s00_axis_tlast  = 1'b0;
    tick();
    tick();
    check("rst_tvalid", 32'(axis.m00_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(axis.m00_axis_tlast), 32'd0);
    check("rst_s_tready", 32'(axis.s00_axis_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    rst = 1'b0;
    tick();

    // 1.0 .. 10.0 in IEEE-754 single precision
    mem_model[0] = 32'h3F800000; mem_model[1] = 32'h40000000;
    mem_model[2] = 32'h40400000; mem_model[3] = 32'h40800000;
    mem_model[4] = 32'h40A00000; mem_model[5] = 32'h40C00000;
    mem_model[6] = 32'h40E00000; mem_model[7] = 32'h41000000;
    mem_model[8] = 32'h41100000; mem_model[9] = 32'h41200000;
    for (int i = 0; i < SIZE; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = mem_model[i];
      tick();
    end
    wr_en = 1'b0;
    tick();

    // back-to-back stream, single result beat
    send_phase(0);
    rx_q.push_back(32'h425C0000);
    recv_phase(0);

    // tready stalls, gapped three-beat result
    send_phase(1);
    rx_q.push_back(32'h00000001);
    rx_q.push_back(32'h00000002);
    rx_q.push_back(32'h40A00000);
    recv_phase(2);

    // start and write during SEND are ignored; mem[3] checked on next run
    send_phase(3);
    rx_q.push_back(32'h11111111);
    recv_phase(1);
    send_phase(0);
    rx_q.push_back(32'h22222222);
    recv_phase(0);

    // reset mid-SEND; operands survive and next run starts from 1.0
    send_phase(2);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_rx_count", 32'(rx_count), 32'd0);
    tick();
    send_phase(0);
    rx_q.push_back(32'h33333333);
    recv_phase(0);

    // out-of-range write dropped
    wr_en   = 1'b1;
    wr_addr = 4'd10;
    wr_data = 32'hFFFFFFFF;
    tick();
    wr_en = 1'b0;
    send_phase(0);
    rx_q.push_back(32'h44444444);
    recv_phase(0);

    // write coinciding with start: the run uses the new word
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 32'h3F000000;
    mem_model[0] = 32'h3F000000;
    send_phase(0);

    // reset mid-RECV
    rst = 1'b1;
    tick();
    check("rst_recv_busy", 32'(busy), 32'd0);
    check("rst_recv_tready", 32'(axis.s00_axis_tready), 32'd0);
    rst = 1'b0;
    tick();
    send_phase(0);
    rx_q.push_back(32'h55555555);
    recv_phase(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
